// File: rtl/equiv_pkg.sv
// rtl/equiv_pkg.sv - shared types, LFSR constants and stimulus field layout for equiv_check_sequencer
package equiv_pkg;

  localparam int LFSR_W = 64;
  localparam logic [LFSR_W-1:0] LFSR_MASK = 64'hD800_0000_0000_0000;

  localparam int W0_W = 8;
  localparam int W1_W = 4;
  localparam int W2_W = 21;
  localparam int W3_W = 19;
  localparam int W0_OFF = 0;
  localparam int W1_OFF = 8;
  localparam int W2_OFF = 12;
  localparam int W3_OFF = 33;
  localparam int STIM_W = W3_OFF + W3_W;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_WARMUP,
    ST_RUN,
    ST_PASS,
    ST_FAIL
  } state_t;

  // Galois right-shift step: the tap mask is folded in when the outgoing bit is 1.
  function automatic logic [LFSR_W-1:0] lfsr_step(input logic [LFSR_W-1:0] x);
    return x[0] ? ((x >> 1) ^ LFSR_MASK) : (x >> 1);
  endfunction

endpackage

// File: rtl/equiv_lfsr.sv
// rtl/equiv_lfsr.sv - 64-bit Galois LFSR with load, zero-seed substitution and enable
module equiv_lfsr
  import equiv_pkg::*;
(
  input  logic              clk,
  input  logic              rst,
  input  logic              load,
  input  logic              en,
  input  logic [LFSR_W-1:0] seed,
  output logic [STIM_W-1:0] nxt_stim
);

  logic [LFSR_W-1:0] q;
  logic [LFSR_W-1:0] d;

  // A zero seed would lock the register at zero forever, so it is replaced by 1.
  always_comb begin
    d = q;
    if (load) begin
      d = (seed == '0) ? {{(LFSR_W-1){1'b0}}, 1'b1} : seed;
    end else if (en) begin
      d = lfsr_step(q);
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) q <= {{(LFSR_W-1){1'b0}}, 1'b1};
    else     q <= d;
  end

  assign nxt_stim = d[STIM_W-1:0];

endmodule

// File: rtl/equiv_check_sequencer.sv
// rtl/equiv_check_sequencer.sv - stimulus scheduler and y_1/y_2 comparator for equivalence runs
// Optional EQUIV_MISMATCH_COUNT_EN: run to completion and count mismatches on mismatch_cnt.
module equiv_check_sequencer
  import equiv_pkg::*;
#(
  parameter int Y_W    = 91,
  parameter int WARMUP = 8,
  parameter int CNT_W  = 16
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    start,
  input  logic [CNT_W-1:0]        num_vectors,
  input  logic [LFSR_W-1:0]       seed,
  output logic signed [W0_W-1:0]  wire0,
  output logic signed [W1_W-1:0]  wire1,
  output logic [W2_W-1:0]         wire2,
  output logic [W3_W-1:0]         wire3,
  input  logic [Y_W-1:0]          y_1,
  input  logic [Y_W-1:0]          y_2,
  output logic                    busy,
  output logic                    done,
  output logic                    pass,
  output logic [CNT_W-1:0]        mismatch_idx,
  output logic [Y_W-1:0]          mismatch_diff
`ifdef EQUIV_MISMATCH_COUNT_EN
  , output logic [CNT_W-1:0]      mismatch_cnt
`endif
);

  localparam logic [7:0] WARM_LAST = (WARMUP > 0) ? 8'(WARMUP - 1) : 8'd0;

  state_t            state, state_nxt;
  logic [7:0]        wcnt;
  logic [CNT_W-1:0]  k;
  logic [CNT_W-1:0]  nv_q;
  logic [STIM_W-1:0] nxt_stim;
  logic              in_busy, nxt_busy, accept, mism, warm_last, run_last, first_mism;

  assign in_busy   = (state == ST_WARMUP) || (state == ST_RUN);
  assign nxt_busy  = (state_nxt == ST_WARMUP) || (state_nxt == ST_RUN);
  assign accept    = start && !in_busy;
  assign mism      = (state == ST_RUN) && (y_1 != y_2);
  assign warm_last = (wcnt == WARM_LAST);
  assign run_last  = (k == nv_q - 1'b1);
`ifdef EQUIV_MISMATCH_COUNT_EN
  assign first_mism = mism && (mismatch_cnt == '0);
`else
  assign first_mism = mism;
`endif

  equiv_lfsr u_lfsr (
    .clk      (clk),
    .rst      (rst),
    .load     (accept),
    .en       (in_busy),
    .seed     (seed),
    .nxt_stim (nxt_stim)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= ST_IDLE;
    else     state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      ST_IDLE, ST_PASS, ST_FAIL: begin
        if (start) begin
          if (WARMUP != 0)              state_nxt = ST_WARMUP;
          else if (num_vectors == '0)   state_nxt = ST_PASS;
          else                          state_nxt = ST_RUN;
        end
      end
      ST_WARMUP: begin
        if (warm_last) state_nxt = (nv_q == '0) ? ST_PASS : ST_RUN;
      end
      ST_RUN: begin
`ifdef EQUIV_MISMATCH_COUNT_EN
        if (run_last) state_nxt = (mismatch_cnt == '0 && !mism) ? ST_PASS : ST_FAIL;
`else
        if (mism)          state_nxt = ST_FAIL;
        else if (run_last) state_nxt = ST_PASS;
`endif
      end
      default: state_nxt = ST_IDLE;
    endcase
  end

  always_comb begin
    busy = 1'b0;
    done = 1'b0;
    pass = 1'b0;
    case (state)
      ST_WARMUP, ST_RUN: busy = 1'b1;
      ST_PASS: begin
        done = 1'b1;
        pass = 1'b1;
      end
      ST_FAIL: done = 1'b1;
      default: ;
    endcase
  end

  // Stimulus mirrors the LFSR while busy and freezes on the last applied vector afterwards.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wcnt          <= '0;
      k             <= '0;
      nv_q          <= '0;
      mismatch_idx  <= '0;
      mismatch_diff <= '0;
      wire0         <= '0;
      wire1         <= '0;
      wire2         <= '0;
      wire3         <= '0;
`ifdef EQUIV_MISMATCH_COUNT_EN
      mismatch_cnt  <= '0;
`endif
    end else begin
      if (accept) begin
        wcnt          <= '0;
        k             <= '0;
        nv_q          <= num_vectors;
        mismatch_idx  <= '0;
        mismatch_diff <= '0;
`ifdef EQUIV_MISMATCH_COUNT_EN
        mismatch_cnt  <= '0;
`endif
      end else if (state == ST_WARMUP) begin
        if (wcnt != 8'hFF) wcnt <= wcnt + 8'd1;
      end else if (state == ST_RUN) begin
        if (k != '1) k <= k + 1'b1;
        if (first_mism) begin
          mismatch_idx  <= k;
          mismatch_diff <= y_1 ^ y_2;
        end
`ifdef EQUIV_MISMATCH_COUNT_EN
        if (mism && mismatch_cnt != '1) mismatch_cnt <= mismatch_cnt + 1'b1;
`endif
      end
      if (nxt_busy) begin
        wire0 <= nxt_stim[W0_OFF +: W0_W];
        wire1 <= nxt_stim[W1_OFF +: W1_W];
        wire2 <= nxt_stim[W2_OFF +: W2_W];
        wire3 <= nxt_stim[W3_OFF +: W3_W];
      end
    end
  end

endmodule

// File: tb/tb_equiv_check_sequencer.sv
// tb/tb_equiv_check_sequencer.sv - self-checking bench for equiv_check_sequencer
module tb_equiv_check_sequencer;

  localparam int Y_W    = 91;
  localparam int WARMUP = 8;
  localparam int CNT_W  = 16;
  localparam logic [Y_W-1:0] BIT90 = {1'b1, 90'b0};
`ifdef EQUIV_MISMATCH_COUNT_EN
  localparam bit CNT_MODE = 1'b1;
`else
  localparam bit CNT_MODE = 1'b0;
`endif

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic start = 1'b0;
  logic [CNT_W-1:0] num_vectors = '0;
  logic [63:0] seed = '0;
  logic signed [7:0] wire0;
  logic signed [3:0] wire1;
  logic [20:0] wire2;
  logic [18:0] wire3;
  logic [Y_W-1:0] y_1, y_2;
  logic [Y_W-1:0] flip = '0;
  logic busy, done, pass;
  logic [CNT_W-1:0] mismatch_idx;
  logic [Y_W-1:0] mismatch_diff;
`ifdef EQUIV_MISMATCH_COUNT_EN
  logic [CNT_W-1:0] mismatch_cnt;
`endif
  logic [38:0] prod;

  int checks = 0;
  int failures = 0;
  int cyc = 0;
  int t0 = 0;
  bit mode = 1'b0;
  int exp_b, exp_idx, exp_cnt;
  bit exp_fail;
  logic [63:0] exp_lfsr [0:511];
  int inj[$];

  equiv_check_sequencer #(.Y_W(Y_W), .WARMUP(WARMUP), .CNT_W(CNT_W)) dut (
    .clk(clk), .rst(rst), .start(start), .num_vectors(num_vectors), .seed(seed),
    .wire0(wire0), .wire1(wire1), .wire2(wire2), .wire3(wire3),
    .y_1(y_1), .y_2(y_2), .busy(busy), .done(done), .pass(pass),
    .mismatch_idx(mismatch_idx), .mismatch_diff(mismatch_diff)
`ifdef EQUIV_MISMATCH_COUNT_EN
    , .mismatch_cnt(mismatch_cnt)
`endif
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  // Two identical combinational "implementations"; y_2 differs only by injected flips.
  assign prod = 39'(wire3) * 39'(wire2);
  assign y_1  = {prod, wire0, wire1, wire2, wire3};
  assign y_2  = y_1 ^ flip;

  task automatic check(input string name, input logic [127:0] got, input logic [127:0] want);
    checks++;
    if (got !== want) begin
      failures++;
      $display("FAIL %s got=%0h want=%0h", name, got, want);
    end
  endtask

  function automatic logic [63:0] step(input logic [63:0] x);
    return x[0] ? ((x >> 1) ^ 64'hD800_0000_0000_0000) : (x >> 1);
  endfunction

  function automatic bit is_inj(input int c);
    foreach (inj[i]) if (inj[i] == c) return 1'b1;
    return 1'b0;
  endfunction

  // Expected run outcome from the rules: warm-up length, first failing RUN index, stimulus trace.
  task automatic plan(input logic [63:0] s, input int nv);
    logic [63:0] x;
    exp_cnt = 0;
    exp_idx = -1;
    for (int kk = 0; kk < nv; kk++) begin
      if (is_inj(WARMUP + kk)) begin
        if (exp_idx < 0) exp_idx = kk;
        exp_cnt++;
        if (!CNT_MODE) break;
      end
    end
    exp_fail = (exp_cnt > 0);
    exp_b = WARMUP + ((exp_fail && !CNT_MODE) ? exp_idx + 1 : nv);
    x = (s == 64'd0) ? 64'd1 : s;
    for (int c = 0; c < exp_b && c < 512; c++) begin
      exp_lfsr[c] = x;
      x = step(x);
    end
  endtask

  task automatic tick();
    int c;
    @(negedge clk);
    c = cyc - t0;
    flip = (mode && c >= 0 && is_inj(c)) ? BIT90 : '0;
  endtask

  task automatic start_run(input logic [63:0] s, input int nv);
    tick();
    seed = s;
    num_vectors = CNT_W'(nv);
    plan(s, nv);
    t0 = cyc + 1;
    mode = 1'b1;
    start = 1'b1;
    tick();
    start = 1'b0;
  endtask

  task automatic wait_done(input int limit, output int nbusy);
    int n;
    n = 0;
    nbusy = 0;
    while (!done && n < limit) begin
      if (busy) nbusy++;
      tick();
      n++;
    end
    if (!done) begin
      failures++;
      $display("FAIL timeout waiting for done after %0d cycles", limit);
    end
  endtask

  always @(posedge clk) begin
    int c, kk;
    bit b;
    logic [63:0] e;
    #1;
    if (!mode) begin
      check("idle_busy", busy, 0);
      check("idle_done", done, 0);
      check("idle_pass", pass, 0);
      check("idle_wire0", $unsigned(wire0), 0);
      check("idle_wire3", wire3, 0);
      check("idle_idx", mismatch_idx, 0);
      check("idle_diff", mismatch_diff, 0);
    end else begin
      c = cyc - t0;
      if (c >= 0) begin
        b = (c < exp_b);
        check("busy", busy, b);
        check("done", done, !b);
        check("pass", pass, !b && !exp_fail);
        if (exp_b > 0) begin
          kk = b ? c : exp_b - 1;
          e = exp_lfsr[kk];
          check("wire0", $unsigned(wire0), e[7:0]);
          check("wire1", $unsigned(wire1), e[11:8]);
          check("wire2", wire2, e[32:12]);
          check("wire3", wire3, e[51:33]);
        end
        if (!b) begin
          check("mismatch_idx", mismatch_idx, exp_fail ? exp_idx : 0);
          check("mismatch_diff", mismatch_diff, exp_fail ? BIT90 : '0);
`ifdef EQUIV_MISMATCH_COUNT_EN
          check("mismatch_cnt", mismatch_cnt, exp_cnt);
`endif
        end
      end
    end
  end

  initial begin
    int nb;
    repeat (3) tick();
    check("reset_busy", busy, 0);
    check("reset_wire2", wire2, 0);
    rst = 1'b0;
    repeat (2) tick();

    // Clean run: 8 warm-up + 100 compared cycles.
    inj = {};
    start_run(64'h1234, 100);
    wait_done(300, nb);
    check("t1_busy_cycles", nb, 108);
    check("t1_pass", pass, 1);
    check("t1_diff", mismatch_diff, 0);
    repeat (3) tick();

    // Bit 90 flipped at RUN index 5.
    inj = {WARMUP + 5};
    start_run(64'hCAFE_F00D_0000_0001, 100);
    wait_done(300, nb);
    check("t2_busy_cycles", nb, CNT_MODE ? 108 : 14);
    check("t2_pass", pass, 0);
    check("t2_idx", mismatch_idx, 5);
    check("t2_diff", mismatch_diff, {1'b1, 90'b0});
    repeat (3) tick();

    // Flips only during warm-up are masked.
    inj = {0, 1, 2, 3, 4, 5, 6, 7};
    start_run(64'hA5A5_5A5A_0F0F_F0F0, 20);
    wait_done(100, nb);
    check("t3_pass", pass, 1);
    repeat (2) tick();

    // Zero vectors with a zero seed: PASS straight after warm-up, stimulus from LFSR=1.
    inj = {};
    start_run(64'd0, 0);
    check("t4_wire0", $unsigned(wire0), 8'h01);
    check("t4_wire1", $unsigned(wire1), 0);
    check("t4_wire2", wire2, 0);
    wait_done(50, nb);
    check("t4_busy_cycles", nb, 8);
    check("t4_pass", pass, 1);
    repeat (2) tick();

    // Mismatch on the final compared cycle must fail.
    inj = {WARMUP + 9};
    start_run(64'h0000_0000_DEAD_BEEF, 10);
    wait_done(100, nb);
    check("t5_pass", pass, 0);
    check("t5_idx", mismatch_idx, 9);
    repeat (2) tick();

    // Reset mid-run at RUN index 40, then a clean restart.
    inj = {};
    start_run(64'h1357_9BDF_2468_ACE0, 100);
    repeat (WARMUP + 40) tick();
    mode = 1'b0;
    rst = 1'b1;
    #1;
    check("t6_rst_busy", busy, 0);
    check("t6_rst_wire0", $unsigned(wire0), 0);
    tick();
    rst = 1'b0;
    tick();
    start_run(64'h0BAD_C0DE_1111_2222, 30);
    wait_done(100, nb);
    check("t6_busy_cycles", nb, 38);
    check("t6_pass", pass, 1);
    repeat (2) tick();

`ifdef EQUIV_MISMATCH_COUNT_EN
    inj = {WARMUP + 3, WARMUP + 7, WARMUP + 9};
    start_run(64'h4242_4242_4242_4242, 16);
    wait_done(100, nb);
    check("t7_busy_cycles", nb, 24);
    check("t7_pass", pass, 0);
    check("t7_cnt", mismatch_cnt, 3);
    check("t7_idx", mismatch_idx, 3);
    repeat (2) tick();
`endif

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
